// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Sequences a multi-cycle processor through fetch, decode, execute, optional
//   data-memory access and optional register writeback. It raises the
//   instruction-register, register-file and PC write strobes, and counts
//   retired instructions. An undefined opcode stops the controller in HALT.
//   A memory request that is not acknowledged in time stops it in ERR.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start
//   FETCH | instruction request outstanding; ack loads the IR
//   DECODE| decoder settles; undefined op with no jump -> HALT
//   EXEC  | dispatch: memory access, writeback, or retire a jump/branch
//   MEM   | data request outstanding; store retires on ack
//   WB    | register write and retire
//   HALT  | terminal, undefined instruction
//   ERR   | terminal, memory ack timeout
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start                      leave IDLE
//   imem_req / imem_ack        instruction fetch handshake
//   ir_we                      instruction-register load strobe
//   op, jump_type, is_load,
//   we_dmem, we_regfile        decoder fields, used combinationally
//   dmem_req/dmem_we/dmem_ack  data memory handshake
//   rf_we, pc_we               register-file and PC write strobes
//   state, halted, err         status
//   retired                    retired-instruction count (wraps)
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic [3:0]       op,
  input  logic [2:0]       jump_type,
  input  logic             is_load,
  input  logic             we_dmem,
  input  logic             we_regfile,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           cur_state;
  state_t           nxt_state;
  logic [TMR_W-1:0] tmr;
  logic             tmr_done;
  logic             wait_entry;
  logic             waiting;

  // Down-counter: loaded with TIMEOUT-1 when a request state is entered, so
  // it reaches terminal count in the TIMEOUT-th unacknowledged cycle.
  assign waiting    = (cur_state == S_FETCH) || (cur_state == S_MEM);
  assign wait_entry = ((nxt_state == S_FETCH) || (nxt_state == S_MEM)) &&
                      (nxt_state != cur_state);
  assign tmr_done   = (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
      tmr       <= '0;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (wait_entry) begin
        tmr <= TMR_W'(TIMEOUT - 1);
      end else if (waiting && !tmr_done) begin
        tmr <= tmr - 1'b1;
      end
      if (pc_we) begin
        retired <= retired + 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // An ack in the terminal-count cycle still wins over the timeout.
        if (imem_ack) begin
          ir_we     = 1'b1;
          nxt_state = S_DECODE;
        end else if (tmr_done) begin
          nxt_state = S_ERR;
        end
      end
      S_DECODE: begin
        if ((op == 4'b1111) && (jump_type == 3'd0)) nxt_state = S_HALT;
        else                                        nxt_state = S_EXEC;
      end
      S_EXEC: begin
        if (is_load || we_dmem) begin
          nxt_state = S_MEM;
        end else if (we_regfile) begin
          nxt_state = S_WB;
        end else begin
          pc_we     = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = we_dmem;
        if (dmem_ack) begin
          if (is_load) begin
            nxt_state = S_WB;
          end else begin
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
          end
        end else if (tmr_done) begin
          nxt_state = S_ERR;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        nxt_state = S_FETCH;
      end
      default: begin
        // HALT and ERR hold until reset.
      end
    endcase
  end

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);
  assign err    = (cur_state == S_ERR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Drives instruction and data memory responses with random delays and
//   random instruction kinds. A reference model predicts, per instruction,
//   the fetch-to-fetch latency, the strobes it must produce and the retired
//   count; a monitor compares these at every retirement (pc_we pulse).
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int WRAP    = 1 << CNT_W;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_BR   = 3;
  localparam int K_HALT = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             imem_req;
  logic             imem_ack;
  logic             ir_we;
  logic [3:0]       op;
  logic [2:0]       jump_type;
  logic             is_load;
  logic             we_dmem;
  logic             we_regfile;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic             rf_we;
  logic             pc_we;
  logic [2:0]       state;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .op(op), .jump_type(jump_type), .is_load(is_load),
    .we_dmem(we_dmem), .we_regfile(we_regfile),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .state(state),
    .halted(halted), .err(err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int lat;        // cycles from first FETCH cycle to the next FETCH
    int mem_cycles; // cycles dmem_req is expected high
    int ret_before; // retired value while this instruction's pc_we is high
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ret  = 0;

  function automatic void chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int cyc, rf_seen, ir_seen, dreq_seen, dwe_seen;
  bit prev_req;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      cyc = 0; rf_seen = 0; ir_seen = 0; dreq_seen = 0; dwe_seen = 0; prev_req = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        cyc = 0; rf_seen = 0; ir_seen = 0; dreq_seen = 0; dwe_seen = 0;
      end else begin
        cyc++;
      end
      prev_req = imem_req;
      rf_seen += int'(rf_we);
      ir_seen += int'(ir_we);
      if (dmem_req) begin
        dreq_seen++;
        dwe_seen += int'(dmem_we);
      end
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pc_we", 1, 0);
        end else begin
          exp_t e;
          bit   writes;
          e = exp_q.pop_front();
          writes = (e.kind == K_ALU) || (e.kind == K_LW);
          chk("latency", cyc + 1, e.lat);
          chk("retired", retired, e.ret_before);
          chk("rf_with_pc", rf_we, writes);
          chk("rf_count", rf_seen, writes ? 1 : 0);
          chk("ir_we_count", ir_seen, 1);
          chk("dmem_req_cycles", dreq_seen, e.mem_cycles);
          chk("dmem_we_cycles", dwe_seen, (e.kind == K_SW) ? e.mem_cycles : 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_decoder(input int kind);
    op = 4'd0; jump_type = 3'd0; is_load = 1'b0; we_dmem = 1'b0; we_regfile = 1'b0;
    case (kind)
      K_ALU: begin op = 4'($urandom_range(0, 14)); we_regfile = 1'b1; end
      K_LW:  begin is_load = 1'b1; we_regfile = 1'b1; end
      K_SW:  begin we_dmem = 1'b1; end
      K_BR:  begin op = 4'($urandom_range(0, 15)); jump_type = 3'($urandom_range(1, 7)); end
      default: begin op = 4'b1111; end
    endcase
  endtask

  // Waits (bounded) for a request; clears acks and start on every negedge.
  task automatic wait_req(input bit data_side, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      start    = 1'b0;
      if (data_side ? dmem_req : imem_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(data_side ? "dmem_req_wait" : "imem_req_wait", 0, 1);
  endtask

  task automatic run_instr(input int kind, input int di, input int dd, input bit trace);
    bit   ok;
    exp_t e;
    bit   mem;
    wait_req(1'b0, ok);
    if (!ok) return;
    mem = (kind == K_LW) || (kind == K_SW);
    if (kind != K_HALT) begin
      e.kind       = kind;
      e.mem_cycles = mem ? dd + 1 : 0;
      e.lat        = (di + 1) + 1 + 1 + e.mem_cycles +
                     (((kind == K_ALU) || (kind == K_LW)) ? 1 : 0);
      e.ret_before = n_ret % WRAP;
      exp_q.push_back(e);
      n_ret++;
    end
    if (trace) chk("trace_fetch", state, 1);
    repeat (di) @(negedge clk);
    imem_ack = 1'b1;
    set_decoder(kind);
    if (trace) begin
      @(negedge clk); imem_ack = 1'b0; chk("trace_decode", state, 2);
      @(negedge clk); chk("trace_exec", state, 3);
      @(negedge clk); chk("trace_wb", state, 5);
    end
    if (mem) begin
      wait_req(1'b1, ok);
      if (!ok) return;
      repeat (dd) @(negedge clk);
      dmem_ack = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_ret = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    op = 4'd0; jump_type = 3'd0; is_load = 1'b0; we_dmem = 1'b0; we_regfile = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_retired", retired, 0);
    chk("reset_strobes", {imem_req, ir_we, dmem_req, rf_we, pc_we, halted, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_without_start", state, 0);

    // Directed instructions, then random ones; more than 2^CNT_W retirements.
    start = 1'b1;
    run_instr(K_ALU, 0, 0, 1'b1);
    run_instr(K_LW, 0, 3, 1'b0);
    run_instr(K_SW, 0, 0, 1'b0);
    run_instr(K_BR, 0, 0, 1'b0);
    run_instr(K_ALU, TIMEOUT - 1, 0, 1'b0);
    run_instr(K_LW, 2, TIMEOUT - 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      int k, di, dd;
      k  = int'($urandom_range(0, 3));
      di = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
      dd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
      run_instr(k, di, dd, 1'b0);
    end

    // Undefined opcode -> HALT; start ignored, retired unchanged.
    run_instr(K_HALT, 1, 0, 1'b0);
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    chk("halt_state", state, 6);
    chk("halted_flag", halted, 1);
    chk("halt_imem_req", imem_req, 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_sticky", state, 6);
    chk("halt_no_strobes", {ir_we, rf_we, pc_we, dmem_req}, 0);
    chk("halt_retired", retired, n_ret % WRAP);
    chk("scoreboard_drained", exp_q.size(), 0);

    // imem ack withheld for TIMEOUT cycles -> ERR.
    do_reset();
    start = 1'b1;
    wait_req(1'b0, ok);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("fetch_last_wait_cycle", state, 1);
    @(negedge clk);
    chk("imem_timeout_state", state, 7);
    chk("err_flag", err, 1);
    chk("err_imem_req", imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_sticky", state, 7);

    // Reset asserted mid-MEM.
    do_reset();
    start = 1'b1;
    run_instr(K_BR, 1, 0, 1'b0);
    wait_req(1'b0, ok);
    imem_ack = 1'b1;
    set_decoder(K_LW);
    wait_req(1'b1, ok);
    repeat (3) @(negedge clk);
    chk("retired_before_reset", retired, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midmem_reset_state", state, 0);
    chk("midmem_reset_dmem_req", dmem_req, 0);
    chk("midmem_reset_retired", retired, 0);
    exp_q.delete();
    n_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Data ack withheld for TIMEOUT cycles on a store -> ERR.
    start = 1'b1;
    wait_req(1'b0, ok);
    imem_ack = 1'b1;
    set_decoder(K_SW);
    wait_req(1'b1, ok);
    chk("sw_dmem_we", dmem_we, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("mem_last_wait_cycle", state, 4);
    @(negedge clk);
    chk("dmem_timeout_state", state, 7);
    chk("err_dmem_req", dmem_req, 0);
    chk("no_retire_after_err", retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
